// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Results are computed at issue, held in p_hi/p_lo, and committed after the op latency.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] p_hi, p_lo, p_hi_nx, p_lo_nx, hi_nx, lo_nx;
  logic             is_mul, is_div, sgn, accept;
  logic [W2-1:0]    ext1, ext2, prod, acc, res_mul;
  logic             s1, s2, dz;
  logic [WIDTH-1:0] mag1, mag2, divisor, qu, ru, q, r, div_hi, div_lo;
  assign is_mul  = op inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10};
  assign is_div  = op inside {4'd3, 4'd4};
  assign sgn     = op inside {4'd1, 4'd3, 4'd7, 4'd9};
  assign accept  = state == IDLE && start && !flush;
  assign busy    = state == RUN;
  // Low 2W bits of the extended product are exact for both signed and unsigned forms
  assign ext1    = {{WIDTH{sgn & in1[WIDTH-1]}}, in1};
  assign ext2    = {{WIDTH{sgn & in2[WIDTH-1]}}, in2};
  assign prod    = ext1 * ext2;
  assign acc     = {hi, lo};
  assign res_mul = op inside {4'd7, 4'd8} ? acc + prod : op inside {4'd9, 4'd10} ? acc - prod : prod;
  // Sign-magnitude divide; most-negative / -1 naturally yields most-negative, remainder 0
  assign s1      = sgn & in1[WIDTH-1];
  assign s2      = sgn & in2[WIDTH-1];
  assign dz      = in2 == '0;
  assign mag1    = s1 ? -in1 : in1;
  assign mag2    = s2 ? -in2 : in2;
  assign divisor = dz ? WIDTH'(1) : mag2;
  assign qu      = mag1 / divisor;
  assign ru      = mag1 % divisor;
  assign q       = (s1 ^ s2) ? -qu : qu;
  assign r       = s1 ? -ru : ru;
  assign div_hi  = dz ? in1 : r;
  assign div_lo  = dz ? '1 : q;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    p_hi_nx  = p_hi;
    p_lo_nx  = p_lo;
    hi_nx    = hi;
    lo_nx    = lo;
    done     = 1'b0;
    if (state == IDLE) begin
      if (accept && is_mul) begin
        {p_hi_nx, p_lo_nx} = res_mul;
        cnt_nx   = CW'(MULT_CYCLES);
        state_nx = RUN;
      end else if (accept && is_div) begin
        {p_hi_nx, p_lo_nx} = {div_hi, div_lo};
        cnt_nx   = CW'(DIV_CYCLES);
        state_nx = RUN;
      end else if (accept) begin
        hi_nx = op == 4'd5 ? in1 : hi;
        lo_nx = op == 4'd6 ? in1 : lo;
      end
    end else if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (cnt == CW'(1)) begin
      hi_nx    = p_hi;
      lo_nx    = p_lo;
      done     = 1'b1;
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      cnt_nx = cnt - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      p_hi  <= p_hi_nx;
      p_lo  <= p_lo_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: vector table plus hand sequences for MT/MADD, flush, reset and busy-start.
module tb_mdu_unit;
  logic        clk = 0, reset = 0, start = 0, flush = 0;
  logic [3:0]  op = 0;
  logic [31:0] in1 = 0, in2 = 0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          total = 0, bad = 0, done_seen = 0, ds;
  logic [63:0] sb[$];
  logic [31:0] mh = 0, ml = 0;
  typedef struct {logic [3:0] op; logic [31:0] a, b, eh, el; int lat;} vec_t;
  vec_t v[10];
  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    #2;
    if (done) done_seen++;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input bit inj, input string nm);
    logic [63:0] e;
    int n = 0, d = 0;
    @(negedge clk);
    op = o; in1 = a; in2 = b; start = 1;
    sb.push_back({eh, el});
    @(negedge clk);
    start = 0;
    while (busy && n < 50) begin
      n++;
      if (done) d = n;
      start = inj && n == 2;
      if (start) begin op = 4'd1; in1 = 100; in2 = 100; end
      @(negedge clk);
    end
    start = 0;
    chk({nm, " lat"}, 64'(n), 64'(lat));
    chk({nm, " done"}, 64'(d), 64'(lat));
    e = sb.pop_front();
    chk({nm, " hilo"}, {hi, lo}, e);
    mh = e[63:32]; ml = e[31:0];
  endtask
  task automatic mt(input logic [3:0] o, input logic [31:0] a, input bit fl);
    @(negedge clk);
    op = o; in1 = a; start = 1; flush = fl;
    @(negedge clk);
    start = 0; flush = 0;
  endtask
  initial begin
    v[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    v[1] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
    v[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    v[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
    v[4] = '{4'd4, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 10};
    v[5] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    v[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    v[7] = '{4'd3, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 10};
    v[8] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5};
    v[9] = '{4'd4, 32'hFFFFFFFF, 32'd16,       32'hF,        32'h0FFFFFFF, 10};
    #2;
    chk("reset state", {30'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 10; i++)
      run_op(v[i].op, v[i].a, v[i].b, v[i].eh, v[i].el, v[i].lat, 0, $sformatf("vec%0d", i));
    ds = done_seen;
    mt(4'd5, 32'd1, 0);
    chk("mthi", {31'd0, busy, hi}, {31'd0, 1'b0, 32'd1});
    mt(4'd6, 32'hFFFFFFFF, 0);
    chk("mtlo", {31'd0, busy, lo}, {31'd0, 1'b0, 32'hFFFFFFFF});
    mt(4'd12, 32'h55, 0);
    chk("nop", {31'd0, busy, hi, lo}, {32'd0, 32'd1, 32'hFFFFFFFF});
    chk("mt no done", 64'(done_seen), 64'(ds));
    run_op(4'd8, 32'd1, 32'd1, 32'd2, 32'd0, 5, 0, "maddu");
    run_op(4'd9, 32'd2, 32'd3, 32'd1, 32'hFFFFFFFA, 5, 0, "msub");
    run_op(4'd7, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFF8, 5, 0, "madd");
    ds = done_seen;
    @(negedge clk);
    op = 4'd1; in1 = 3; in2 = 4; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush mid", {31'd0, busy, hi, lo}, {32'd0, mh, ml});
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush commit", {31'd0, busy, hi, lo}, {32'd0, mh, ml});
    repeat (3) @(negedge clk);
    chk("flush commit late", {31'd0, busy, hi, lo}, {32'd0, mh, ml});
    mt(4'd1, 32'd9, 1);
    chk("start+flush", {31'd0, busy, hi, lo}, {32'd0, mh, ml});
    mt(4'd5, 32'hDEAD, 1);
    chk("mthi+flush", {32'd0, hi}, {32'd0, mh});
    chk("flush no done", 64'(done_seen), 64'(ds));
    @(negedge clk);
    op = 4'd3; in1 = 100; in2 = 7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #1 reset = 0;
    #1 chk("async reset", {31'd0, busy, hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1;
    run_op(4'd2, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1, "busy start");
    repeat (3) @(negedge clk);
    chk("busy start idle", {31'd0, busy, hi, lo}, {32'd0, 32'd0, 32'd42});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multiply/divide unit for the E stage of the five-stage pipeline. It replaces the fixed 32-bit MDU and adds:
- configurable operand width and per-class latencies;
- multiply-accumulate/subtract ops;
- defined divide-by-zero and overflow results;
- a flush input that cancels an in-flight operation.

HI/LO are architectural state held here. They feed the M/W forwarding paths and the MFHI/MFLO write-back.

## Interface
- WIDTH, 32, operand and HI/LO width (≥8)
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle request from E stage, qualifies op
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 treated as NOP
- in1  in  WIDTH  rs operand (dividend / multiplicand / MTxx source)
- in2  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  cancel in-flight operation; suppress same-cycle start
- busy  out  1  operation in progress (excludes the start cycle)
- done  out  1  one-cycle pulse on the cycle HI/LO commit
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Two-state FSM: IDLE, RUN. A down-counter of width clog2(max(MULT_CYCLES,DIV_CYCLES)+1) runs alongside. Pending registers p_hi/p_lo hold the result.
- IDLE, start=1, flush=0, op multiply/divide class:
  - compute the result combinationally from in1/in2 (and current hi/lo for MADD/MSUB class);
  - capture it into p_hi/p_lo;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, start=1, op MTHI/MTLO: hi or lo ← in1 at that edge. No RUN, no done. The other register is unchanged.
- RUN: decrement each cycle. When the counter reaches 1:
  - hi←p_hi, lo←p_lo;
  - done=1 for that cycle;
  - return to IDLE.
- busy = (state==RUN).
- Arithmetic, with P the 2·WIDTH product:
  - MULT is signed, MULTU unsigned; {hi,lo}=P.
  - MADD(U): {hi,lo}+P. MSUB(U): {hi,lo}−P. Modulo 2^(2·WIDTH).
  - DIV: lo = quotient truncated toward zero, hi = remainder with the dividend's sign. DIVU is unsigned.
- Divide by zero (in2=0): lo = all ones, hi = in1. Latency is unchanged.
- Signed overflow (DIV of most-negative by −1): lo = most-negative value, hi = 0.
- start while busy: ignored. The hazard unit stalls D on (start&mdu-class)|busy, so this is illegal upstream. The unit must not corrupt p_hi/p_lo.
- start with op NOP or 11–15: no effect.
- flush=1 in RUN: return to IDLE at the next edge. hi/lo keep their pre-operation values, and done is not asserted. If flush coincides with the commit cycle, flush wins (no commit).
- flush=1 with start=1 in IDLE: start ignored, including MTHI/MTLO.
- reset low at any time: immediately IDLE, counter 0, hi=lo=p_hi=p_lo=0, busy=0, done=0.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0.
- start sampled at edge t, latency N (MULT_CYCLES or DIV_CYCLES):
  - busy=1 during cycles t+1 … t+N;
  - done=1 in cycle t+N;
  - new hi/lo visible after edge t+N;
  - busy=0 from cycle t+N+1.
- A new start is accepted in cycle t+N+1. Back-to-back ops carry no dead cycle beyond that.
- MADD/MSUB use hi/lo as sampled at the start edge, not at commit.
- MTHI/MTLO: result visible after the start edge, latency 1, busy stays 0.
- hi/lo are pure register outputs, with no combinational path from inputs.

## Test plan
- Reset, then MULT in1=0xFFFFFFFD, in2=5 (WIDTH=32, MULT_CYCLES=5) -> busy high exactly 5 cycles; done pulse in 5th; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 7/2, then DIV 0xFFFFFFF9/2 -> first hi=1, lo=3 after 10 busy cycles; second hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF and DIVU 0x1234/0 -> first lo=0x80000000, hi=0; second lo=0xFFFFFFFF, hi=0x1234.
- MTHI 1, MTLO 0xFFFFFFFF, MADDU 1×1, then MSUB 2×3 -> hi/lo=1/0xFFFFFFFF after the MT ops with busy never set; after MADDU hi=2, lo=0; after MSUB hi=1, lo=0xFFFFFFFA.
- MULT 3×4 with flush at busy cycle 2, then flush coincident with the commit cycle of a second MULT, then start+flush same cycle -> hi/lo unchanged in all three cases; busy=0 the cycle after each flush; done never pulses.
- reset low during RUN of DIV -> busy, hi, lo all 0 immediately. After release, a start issued while busy is asserted is ignored: the result equals the first op's alone.
